// File: rtl/fde_pkg.sv
// Shared encodings for the fetch/decode/execute pipeline: opcodes, functs,
// ALU operations, control-word layout and ID_EX field placement.
package fde_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_e;

    localparam int CTRL_DEST_LSB    = 0;
    localparam int CTRL_DEST_W      = 5;
    localparam int CTRL_REG_WRITE   = 5;
    localparam int CTRL_MEM_READ    = 6;
    localparam int CTRL_MEM_WRITE   = 7;
    localparam int CTRL_BRANCH      = 8;
    localparam int CTRL_JUMP        = 9;
    localparam int CTRL_ALU_SRC_IMM = 10;
    localparam int CTRL_ALU_OP_LSB  = 11;
    localparam int CTRL_ILLEGAL     = 15;
    localparam int CTRL_USED_W      = 16;

    // Packed so that member order reproduces the bit positions above.
    typedef struct packed {
        logic       illegal;
        alu_op_e    alu_op;
        logic       alu_src_imm;
        logic       jump;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic [4:0] dest;
    } ctrl_t;

    // ID_EX = {ctrl, pc4, rs_val, rt_val, imm, tgt}; slots count up from the LSB.
    localparam int SLOT_TGT  = 0;
    localparam int SLOT_IMM  = 1;
    localparam int SLOT_RT   = 2;
    localparam int SLOT_RS   = 3;
    localparam int SLOT_PC4  = 4;
    localparam int SLOT_CTRL = 5;

    function automatic int field_lsb(input int slot, input int xlen);
        return slot * xlen;
    endfunction

    function automatic int idex_w(input int xlen, input int ctrl_w);
        return ctrl_w + 5 * xlen;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two combinational read ports with same-cycle write-back bypass and one
// synchronous write port; register 0 is hardwired to zero.
module regfile_2r1w #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [RW-1:0]   rs_idx,
    input  logic [RW-1:0]   rt_idx,
    output logic [XLEN-1:0] rs_val,
    output logic [XLEN-1:0] rt_val,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_idx,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [NREGS];

    // Index 0 and indices past the last register neither store nor read.
    function automatic logic live_idx(input logic [RW-1:0] idx);
        return (idx != '0) && (32'(idx) < NREGS);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && live_idx(wb_idx)) begin
            regs[wb_idx] <= wb_data;
        end
    end

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (live_idx(rs_idx)) begin
            rs_val = (wb_en && wb_idx == rs_idx) ? wb_data : regs[rs_idx];
        end
        if (live_idx(rt_idx)) begin
            rt_val = (wb_en && wb_idx == rt_idx) ? wb_data : regs[rt_idx];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: MIPS-subset decoder, operand read and a valid/ready output
// register with load-use stall and flush.
module decode_stage
    import fde_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int CTRL_W = 16,
    localparam int RW     = $clog2(NREGS),
    localparam int IDEX_W = idex_w(XLEN, CTRL_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [XLEN+31:0]  IF_ID,
    input  logic              if_valid,
    output logic              if_ready,
    output logic [IDEX_W-1:0] ID_EX,
    output logic              id_valid,
    input  logic              ex_ready,
    input  logic              wb_en,
    input  logic [RW-1:0]     wb_idx,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush
);

    localparam int CTRL_LSB = field_lsb(SLOT_CTRL, XLEN);

    logic [XLEN-1:0]   pc, pc4, imm, tgt, rs_val, rt_val;
    logic [31:0]       instr;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    ctrl_t             ctrl_d;
    logic [CTRL_W-1:0] ctrl_bus;
    logic [IDEX_W-1:0] id_ex_d, id_ex_q;
    logic              id_valid_q;
    logic              load_en, hazard, uses_rt;
    logic [4:0]        ex_dest;
    logic              ex_mem_read;
    logic              unused_shamt;

    assign pc     = IF_ID[XLEN+31:32];
    assign instr  = IF_ID[31:0];
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        ctrl_d = '0;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl_d.dest      = rd;
                ctrl_d.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl_d.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_d.alu_op = ALU_SUB;
                    FN_AND:  ctrl_d.alu_op = ALU_AND;
                    FN_OR:   ctrl_d.alu_op = ALU_OR;
                    FN_SLT:  ctrl_d.alu_op = ALU_SLT;
                    default: begin
                        ctrl_d         = '0;
                        ctrl_d.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_LW: begin
                ctrl_d.dest        = rt;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.alu_op      = ALU_ADD;
                ctrl_d.mem_read    = (opcode == OP_LW);
            end
            OP_SW: begin
                ctrl_d.mem_write   = 1'b1;
                ctrl_d.alu_src_imm = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = ALU_SUB;
            end
            OP_J: begin
                ctrl_d.jump = 1'b1;
            end
            default: begin
                ctrl_d.illegal = 1'b1;
            end
        endcase
        if (ctrl_d.dest == 5'd0) begin
            ctrl_d.reg_write = 1'b0;
        end
    end

    always_comb begin
        ctrl_bus = '0;
        ctrl_bus[CTRL_USED_W-1:0] = ctrl_d;
    end

    assign pc4 = pc + XLEN'(4);
    assign imm = {{(XLEN-16){instr[15]}}, instr[15:0]};

    always_comb begin
        if (opcode == OP_J) begin
            tgt = {pc4[XLEN-1:28], instr[25:0], 2'b00};
        end else begin
            tgt = pc4 + (imm << 2);
        end
    end

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .rs_idx  (RW'(rs)),
        .rt_idx  (RW'(rt)),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .wb_en   (wb_en),
        .wb_idx  (wb_idx),
        .wb_data (wb_data)
    );

    assign id_ex_d = {ctrl_bus, pc4, rs_val, rt_val, imm, tgt};

    // A load in the output register cannot forward to the word behind it.
    assign ex_dest     = id_ex_q[CTRL_LSB+CTRL_DEST_LSB +: CTRL_DEST_W];
    assign ex_mem_read = id_ex_q[CTRL_LSB+CTRL_MEM_READ];
    assign uses_rt     = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign hazard      = id_valid_q && ex_mem_read && (ex_dest != 5'd0) && if_valid &&
                         ((ex_dest == rs) || ((ex_dest == rt) && uses_rt));

    assign load_en  = !id_valid_q || ex_ready;
    assign if_ready = load_en && !hazard && !reset;

    // Flush kills the slot but still reports ready so fetch moves past the word.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            id_ex_q    <= '0;
        end else if (flush) begin
            id_valid_q <= 1'b0;
        end else if (load_en) begin
            if (if_valid && if_ready) begin
                id_ex_q    <= id_ex_d;
                id_valid_q <= 1'b1;
            end else begin
                id_valid_q <= 1'b0;
            end
        end
    end

    assign ID_EX    = id_ex_q;
    assign id_valid = id_valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed ID_EX images and handshake
// behaviour checked with immediate assertions.
module tb_decode_stage;

    logic         clock = 1'b0;
    logic         reset;
    logic [63:0]  IF_ID;
    logic         if_valid;
    logic         if_ready;
    logic [175:0] ID_EX;
    logic         id_valid;
    logic         ex_ready;
    logic         wb_en;
    logic [4:0]   wb_idx;
    logic [31:0]  wb_data;
    logic         flush;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clock    (clock),
        .reset    (reset),
        .IF_ID    (IF_ID),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .ID_EX    (ID_EX),
        .id_valid (id_valid),
        .ex_ready (ex_ready),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
        .flush    (flush)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr);
        IF_ID    = {pc, instr};
        if_valid = 1'b1;
    endtask

    function automatic logic [175:0] vec(input logic [15:0] c, input logic [31:0] p4,
                                         input logic [31:0] rsv, input logic [31:0] rtv,
                                         input logic [31:0] im, input logic [31:0] tg);
        return {c, p4, rsv, rtv, im, tg};
    endfunction

    initial begin
        reset = 1'b1; IF_ID = '0; if_valid = 1'b0; ex_ready = 1'b1;
        wb_en = 1'b0; wb_idx = '0; wb_data = '0; flush = 1'b0;
        #1;
        chk("rst_if_ready", if_ready, 1'b0);
        tick();
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_ex", ID_EX, 176'd0);
        reset = 1'b0;

        // addi $1,$0,5
        present(32'h0040_0000, 32'h2001_0005);
        #1 chk("addi_if_ready", if_ready, 1'b1);
        tick();
        chk("addi_valid", id_valid, 1'b1);
        chk("addi_vec", ID_EX, vec(16'h0421, 32'h0040_0004, 32'h0, 32'h0, 32'h5, 32'h0040_0018));

        // add $4,$3,$3 with same-cycle write-back of $3
        present(32'h0040_0004, 32'h0063_2020);
        wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0;
        chk("bypass_vec", ID_EX, vec(16'h0024, 32'h0040_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                     32'h0000_2020, 32'h0040_8088));

        // add $6,$3,$0 reads the stored $3
        present(32'h0040_0008, 32'h0060_3020);
        tick();
        chk("stored_rs", ID_EX[127:96], 32'hDEAD_BEEF);
        chk("stored_rt", ID_EX[95:64], 32'h0);

        // lw $2,0($1) then add $5,$2,$2: one stall cycle
        present(32'h0000_0200, 32'h8C22_0000);
        tick();
        chk("lw_ctrl", ID_EX[175:160], 16'h0462);
        present(32'h0000_0204, 32'h0042_2820);
        #1 chk("luse_if_ready_low", if_ready, 1'b0);
        tick();
        chk("luse_bubble", id_valid, 1'b0);
        chk("luse_if_ready_back", if_ready, 1'b1);
        tick();
        chk("luse_add_valid", id_valid, 1'b1);
        chk("luse_add_vec", ID_EX, vec(16'h0025, 32'h0000_0208, 32'h0, 32'h0,
                                       32'h0000_2820, 32'h0000_A288));

        // Backpressure for 3 cycles with addi $7,$0,7 waiting
        present(32'h0000_0300, 32'h2007_0007);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_if_ready", if_ready, 1'b0);
            tick();
            chk("bp_valid", id_valid, 1'b1);
            chk("bp_vec", ID_EX, vec(16'h0025, 32'h0000_0208, 32'h0, 32'h0,
                                     32'h0000_2820, 32'h0000_A288));
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", if_ready, 1'b1);
        tick();
        chk("bp_next_vec", ID_EX, vec(16'h0427, 32'h0000_0304, 32'h0, 32'h0, 32'h7, 32'h0000_0320));
        if_valid = 1'b0;
        tick();
        chk("bp_no_dup", id_valid, 1'b0);

        // beq $1,$2,-1 and j 0x40
        present(32'h0000_0100, 32'h1022_FFFF);
        tick();
        chk("beq_ctrl", ID_EX[175:160], 16'h0900);
        chk("beq_imm", ID_EX[63:32], 32'hFFFF_FFFF);
        chk("beq_tgt", ID_EX[31:0], 32'h0000_0100);
        present(32'h0000_0100, 32'h0800_0040);
        tick();
        chk("j_ctrl", ID_EX[175:160], 16'h0200);
        chk("j_tgt", ID_EX[31:0], 32'h0000_0100);

        // Illegal opcode, illegal funct, write to $0
        present(32'h0000_0104, 32'hFC00_0000);
        tick();
        chk("illegal_op_ctrl", ID_EX[175:160], 16'h8000);
        present(32'h0000_0108, 32'h0000_0001);
        tick();
        chk("illegal_fn_ctrl", ID_EX[175:160], 16'h8000);
        present(32'h0000_010C, 32'h2000_0001);
        tick();
        chk("dest0_ctrl", ID_EX[175:160], 16'h0400);

        // Flush with concurrent write-back of $1
        present(32'h0000_0110, 32'h0000_4020);
        flush = 1'b1; wb_en = 1'b1; wb_idx = 5'd1; wb_data = 32'h1111_1111;
        #1 chk("flush_if_ready", if_ready, 1'b1);
        tick();
        flush = 1'b0; wb_en = 1'b0;
        chk("flush_valid", id_valid, 1'b0);
        present(32'h0000_0114, 32'h0020_0820);
        tick();
        chk("flush_wb_valid", id_valid, 1'b1);
        chk("flush_wb_rs", ID_EX[127:96], 32'h1111_1111);

        // Write-back to $0 is not bypassed
        present(32'h0000_0118, 32'h0000_4020);
        wb_en = 1'b1; wb_idx = 5'd0; wb_data = 32'hFFFF_0000;
        tick();
        wb_en = 1'b0;
        chk("r0_rs", ID_EX[127:96], 32'h0);
        chk("r0_rt", ID_EX[95:64], 32'h0);

        // Reset mid-stream together with wb_en
        reset = 1'b1; wb_en = 1'b1; wb_idx = 5'd1; wb_data = 32'h2222_2222;
        present(32'h0000_011C, 32'h2001_0005);
        #1 chk("rst2_if_ready", if_ready, 1'b0);
        tick();
        reset = 1'b0; wb_en = 1'b0;
        chk("rst2_valid", id_valid, 1'b0);
        chk("rst2_id_ex", ID_EX, 176'd0);
        present(32'h0000_0000, 32'h0020_0820);
        tick();
        chk("rst2_read_valid", id_valid, 1'b1);
        chk("rst2_read_r1", ID_EX[127:96], 32'h0);

        if_valid = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, handshaked successor to the combinational-latch decoder; sits between fetch (IF_ID) and execute (ID_EX) in the fetch_decode_execute pipeline.
- Decodes a 32-bit MIPS-subset instruction and reads two operands from an internal 2R1W register file that has write-back bypass.
- Registers the result with valid/ready flow control, load-use stall detection and flush.
- At default parameters ID_EX is 176 bits.

Parameters:
- XLEN, 32, datapath/PC width; must be >= 32.
- NREGS, 32, register count; index width RW = clog2(NREGS), must be >= 5.
- CTRL_W, 16, control-field width; must be >= 16.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- IF_ID  in  XLEN+32  {pc, instr}
- if_valid  in  1  IF_ID holds an instruction
- if_ready  out  1  decode accepts IF_ID this cycle
- ID_EX  out  CTRL_W+5*XLEN  {ctrl, pc4, rs_val, rt_val, imm, tgt}
- id_valid  out  1  ID_EX holds a live instruction
- ex_ready  in  1  execute accepts ID_EX this cycle
- wb_en  in  1  register write enable
- wb_idx  in  RW  write index
- wb_data  in  XLEN  write data
- flush  in  1  kill the instruction in decode (branch taken)

Behaviour:
- Reset (synchronous, highest priority):
  - id_valid=0 and ID_EX=0.
  - All registers cleared.
  - if_ready=0 during the reset cycle.
- ctrl bit fields:
  - [4:0] dest
  - [5] reg_write
  - [6] mem_read
  - [7] mem_write
  - [8] branch
  - [9] jump
  - [10] alu_src_imm
  - [14:11] alu_op (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT)
  - [15] illegal
  - Bits above 15 are zero.
- Decode by opcode:
  - 0x00 R-type: funct 0x20/22/24/25/2A map to alu_op 0–4, dest=rd, reg_write=1. Any other funct gives illegal=1 with all enables 0.
  - 0x08 addi: dest=rt, reg_write=1, alu_src_imm=1, alu_op=ADD.
  - 0x23 lw: as addi, plus mem_read=1.
  - 0x2B sw: mem_write=1, alu_src_imm=1, dest=0.
  - 0x04 beq: branch=1, alu_op=SUB.
  - 0x02 j: jump=1.
  - Any other opcode: illegal=1, all enables 0.
  - Write to register 0 (dest==0): reg_write forced to 0.
- Datapath fields:
  - pc4 = pc+4, modulo 2^XLEN.
  - imm = sign-extended instr[15:0].
  - tgt for j = {pc4[XLEN-1:28], instr[25:0], 2'b00}.
  - tgt for all other opcodes = pc4 + (imm<<2), modulo 2^XLEN.
- Register file:
  - Register 0 reads as 0 and ignores writes.
  - Write-back happens at the clock edge when wb_en=1.
  - Same-cycle bypass: when wb_en && wb_idx==rs && rs!=0, rs_val=wb_data; likewise for rt.
  - wb_idx >= NREGS: write ignored.
- Handshake:
  - load_en = !id_valid || ex_ready.
  - hazard = id_valid && ctrl.mem_read && ctrl.dest!=0 && if_valid && (dest==rs || (dest==rt && incoming is R-type/sw/beq)).
  - if_ready = load_en && !hazard && !reset.
- Registered stage, one cycle latency. When load_en is 1, the output register updates at the next edge:
  - if_valid && if_ready: ID_EX=decoded instruction, id_valid=1.
  - Otherwise: id_valid=0 (bubble); ID_EX holds its old value.
  - Hazard case: exactly one bubble is emitted, and the instruction is re-presented and accepted the following cycle.
- When load_en is 0: ID_EX and id_valid hold unchanged. The stable-under-backpressure rule is mandatory.
- flush=1:
  - Next edge: id_valid=0.
  - The IF_ID word present that cycle is dropped, although if_ready is still reported so that fetch advances.
  - flush overrides both load and hold.
  - Write-back still occurs.
- Simultaneous events:
  - Write-back and read of the same index in one cycle: the new data is used.
  - Reset together with wb_en: reset wins.

Decomposition:
- Package fde_pkg holds:
  - opcode and funct constants;
  - alu_op encodings;
  - ctrl bit positions;
  - ID_EX field offsets as functions of XLEN and CTRL_W.
- Sub-module regfile_2r1w (parameters XLEN, NREGS): two combinational read ports with write-bypass, one synchronous write port, synchronous clear.
- Decode logic and the handshake register stay in decode_stage.

Test Plan:
- addi $1,$0,5 (0x20010005) at pc 0x00400000, ex_ready=1:
  - Next edge: id_valid=1, dest=1, reg_write=1, alu_src_imm=1, alu_op=0.
  - imm=0x00000005, pc4=0x00400004.
- wb_en=1, wb_idx=3, wb_data=0xDEADBEEF in the same cycle that add $4,$3,$3 (0x00632020) is presented:
  - rs_val=rt_val=0xDEADBEEF.
  - A later read of $3 also returns 0xDEADBEEF.
- lw $2,0($1) (0x8C220000) followed by add $5,$2,$2 (0x00422820):
  - if_ready=0 for exactly one cycle; one id_valid=0 bubble.
  - The add then issues.
- Backpressure, ex_ready=0 for 3 cycles while if_valid=1:
  - ID_EX and id_valid are bit-stable; if_ready=0.
  - On release, the next instruction follows with no loss or duplication.
- beq $1,$2,-1 (0x1022FFFF) at pc 0x100: imm=0xFFFFFFFF, tgt=0x100, branch=1. j 0x40 (0x08000040) at pc 0x100: tgt=0x100.
- Illegal opcode 0xFC000000, then flush and reset mid-stream:
  - Illegal instruction: illegal=1, reg_write=0.
  - flush: the next edge gives id_valid=0.
  - reset: the next edge gives ID_EX=0, and a read of $1 returns 0.
